// File: rtl/rfarb_pkg.sv
// Shared types and defaults for the register-file access controller.
package rfarb_pkg;

    localparam int          DW_DEF       = 16;
    localparam int          AW_DEF       = 3;
    localparam logic [15:0] INIT_VAL_DEF = 16'h0000;
    localparam int          NREQ         = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way picker: one-hot grant from an eligibility vector and last-winner pointer.
// RFARB_FIXED_PRIO_EN makes requester 0 win every tie instead of alternating.
module rr_arb2
    import rfarb_pkg::*;
(
    input  logic [NREQ-1:0] i_elig,
    input  logic            i_lp,
    output logic [NREQ-1:0] o_gnt
);

`ifdef RFARB_FIXED_PRIO_EN
    logic w_unused_lp;
    assign w_unused_lp = i_lp;
`endif

    always_comb begin
        o_gnt = i_elig;
        if (&i_elig) begin
`ifdef RFARB_FIXED_PRIO_EN
            o_gnt = 2'b01;
`else
            // Tie goes to whoever did not win last time.
            o_gnt = i_lp ? 2'b01 : 2'b10;
`endif
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester controller for an 8x16 dual-read/single-write register file:
// initialises every register after reset, then grants one transaction per cycle.
// Tie policy selected by RFARB_FIXED_PRIO_EN (see rr_arb2).
module regfile_arbiter
    import rfarb_pkg::*;
#(
    parameter int             DW       = DW_DEF,
    parameter int             AW       = AW_DEF,
    parameter logic [DW-1:0]  INIT_VAL = DW'(INIT_VAL_DEF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] wadr0,
    input  logic [AW-1:0] wadr1,
    input  logic [DW-1:0] wdat0,
    input  logic [DW-1:0] wdat1,
    input  logic [AW-1:0] radr0,
    input  logic [AW-1:0] radr1,
    input  logic [AW-1:0] sadr0,
    input  logic [AW-1:0] sadr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdat0,
    output logic [DW-1:0] rdat1,
    output logic [DW-1:0] sdat0,
    output logic [DW-1:0] sdat1,
    output logic          vld0,
    output logic          vld1,
    output logic [DW-1:0] rf_W,
    output logic [AW-1:0] rf_W_Adr,
    output logic          rf_we,
    output logic [AW-1:0] rf_R_Adr,
    output logic [AW-1:0] rf_S_Adr,
    input  logic [DW-1:0] rf_R,
    input  logic [DW-1:0] rf_S,
    output logic          init_done
);

    localparam int            NREG     = 2 ** AW;
    localparam logic [AW:0]   CNT_DONE = (AW + 1)'(NREG);

    state_t          r_state;
    logic [AW:0]     r_cnt;
    logic            r_lp;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_vld;
    logic [DW-1:0]   r_rdat0, r_rdat1, r_sdat0, r_sdat1;
    logic [DW-1:0]   r_rf_W;
    logic [AW-1:0]   r_rf_W_Adr, r_rf_R_Adr, r_rf_S_Adr;
    logic            r_rf_we;
    logic            r_init_done;

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_pick;
    logic            w_sel;
    logic            w_we;
    logic [AW-1:0]   w_wadr, w_radr, w_sadr;
    logic [DW-1:0]   w_wdat;

    // A requester whose grant is showing this cycle is still holding the old request.
    assign w_elig = {req1 & ~r_gnt[1], req0 & ~r_gnt[0]};

    rr_arb2 u_pick (
        .i_elig (w_elig),
        .i_lp   (r_lp),
        .o_gnt  (w_pick)
    );

    assign w_sel  = w_pick[1];
    assign w_we   = w_sel ? we1   : we0;
    assign w_wadr = w_sel ? wadr1 : wadr0;
    assign w_wdat = w_sel ? wdat1 : wdat0;
    assign w_radr = w_sel ? radr1 : radr0;
    assign w_sadr = w_sel ? sadr1 : sadr0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_lp        <= 1'b1;
            r_gnt       <= '0;
            r_vld       <= '0;
            r_rdat0     <= '0;
            r_rdat1     <= '0;
            r_sdat0     <= '0;
            r_sdat1     <= '0;
            r_rf_W      <= '0;
            r_rf_W_Adr  <= '0;
            r_rf_R_Adr  <= '0;
            r_rf_S_Adr  <= '0;
            r_rf_we     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            // Read data is captured at the edge that commits the granted write.
            r_vld <= r_gnt;
            if (r_gnt[0]) begin
                r_rdat0 <= rf_R;
                r_sdat0 <= rf_S;
            end
            if (r_gnt[1]) begin
                r_rdat1 <= rf_R;
                r_sdat1 <= rf_S;
            end

            if (r_state == ST_INIT) begin
                r_gnt <= '0;
                if (r_cnt == CNT_DONE) begin
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
                    r_rf_we     <= 1'b0;
                end else begin
                    r_rf_we    <= 1'b1;
                    r_rf_W     <= INIT_VAL;
                    r_rf_W_Adr <= r_cnt[AW-1:0];
                    r_cnt      <= r_cnt + 1'b1;
                end
            end else begin
                r_gnt <= w_pick;
                if (|w_pick) begin
                    r_lp       <= w_sel;
                    r_rf_we    <= w_we;
                    r_rf_W     <= w_wdat;
                    r_rf_W_Adr <= w_wadr;
                    r_rf_R_Adr <= w_radr;
                    r_rf_S_Adr <= w_sadr;
                end else begin
                    r_rf_we <= 1'b0;
                end
            end
        end
    end

    assign gnt0      = r_gnt[0];
    assign gnt1      = r_gnt[1];
    assign vld0      = r_vld[0];
    assign vld1      = r_vld[1];
    assign rdat0     = r_rdat0;
    assign rdat1     = r_rdat1;
    assign sdat0     = r_sdat0;
    assign sdat1     = r_sdat1;
    assign rf_W      = r_rf_W;
    assign rf_W_Adr  = r_rf_W_Adr;
    assign rf_we     = r_rf_we;
    assign rf_R_Adr  = r_rf_R_Adr;
    assign rf_S_Adr  = r_rf_S_Adr;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: behavioural register file, shadow contents model,
// per-requester expected queues checked whenever a vld pulse appears.
module tb_regfile_arbiter;

`ifdef RFARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [2:0]  wadr0 = '0, wadr1 = '0, radr0 = '0, radr1 = '0, sadr0 = '0, sadr1 = '0;
    logic [15:0] wdat0 = '0, wdat1 = '0;
    logic        gnt0, gnt1, vld0, vld1, rf_we, init_done;
    logic [15:0] rdat0, rdat1, sdat0, sdat1, rf_W, rf_R, rf_S;
    logic [2:0]  rf_W_Adr, rf_R_Adr, rf_S_Adr;

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .wadr0(wadr0), .wadr1(wadr1), .wdat0(wdat0), .wdat1(wdat1),
        .radr0(radr0), .radr1(radr1), .sadr0(sadr0), .sadr1(sadr1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdat0(rdat0), .rdat1(rdat1), .sdat0(sdat0), .sdat1(sdat1),
        .vld0(vld0), .vld1(vld1),
        .rf_W(rf_W), .rf_W_Adr(rf_W_Adr), .rf_we(rf_we),
        .rf_R_Adr(rf_R_Adr), .rf_S_Adr(rf_S_Adr),
        .rf_R(rf_R), .rf_S(rf_S),
        .init_done(init_done)
    );

    // Behavioural register file, seeded with non-zero garbage so INIT is visible.
    logic [15:0] rf_mem [8];
    logic        seeded = 1'b0;
    assign rf_R = rf_mem[rf_R_Adr];
    assign rf_S = rf_mem[rf_S_Adr];
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'hA5A0 + 16'(i);
            seeded <= 1'b1;
        end else if (rf_we) begin
            rf_mem[rf_W_Adr] <= rf_W;
        end
    end

    logic [15:0] shadow [8];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        mon_en = 1'b0;
    logic        s_rst  = 1'b0;
    logic        p_gnt0 = 1'b0, p_gnt1 = 1'b0;
    logic [31:0] e0, e1;

    always @(posedge clk) s_rst <= reset;

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_rst) begin
                chk("vld0_lat", 32'(vld0), 32'(p_gnt0));
                chk("vld1_lat", 32'(vld1), 32'(p_gnt1));
            end else begin
                chk("vld0_rst", 32'(vld0), 32'd0);
                chk("vld1_rst", 32'(vld1), 32'd0);
            end
            chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
            if (!init_done) chk("gnt_init", 32'(gnt0 | gnt1), 32'd0);
            if (vld0) begin
                if (exp_q0.size() == 0) chk("vld0_unexp", 32'(exp_q0.size()), 32'd1);
                else begin
                    e0 = exp_q0.pop_front();
                    chk("rdat0", 32'(rdat0), 32'(e0[31:16]));
                    chk("sdat0", 32'(sdat0), 32'(e0[15:0]));
                end
            end
            if (vld1) begin
                if (exp_q1.size() == 0) chk("vld1_unexp", 32'(exp_q1.size()), 32'd1);
                else begin
                    e1 = exp_q1.pop_front();
                    chk("rdat1", 32'(rdat1), 32'(e1[31:16]));
                    chk("sdat1", 32'(sdat1), 32'(e1[15:0]));
                end
            end
        end
        p_gnt0 = gnt0;
        p_gnt1 = gnt1;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int k, input logic req, input logic we,
                         input logic [2:0] wadr, input logic [15:0] wdat,
                         input logic [2:0] radr, input logic [2:0] sadr);
        if (k == 0) begin
            req0 = req; we0 = we; wadr0 = wadr; wdat0 = wdat; radr0 = radr; sadr0 = sadr;
        end else begin
            req1 = req; we1 = we; wadr1 = wadr; wdat1 = wdat; radr1 = radr; sadr1 = sadr;
        end
    endtask

    task automatic push_exp(input int k, input logic [2:0] radr, input logic [2:0] sadr);
        if (k == 0) exp_q0.push_back({shadow[radr], shadow[sadr]});
        else        exp_q1.push_back({shadow[radr], shadow[sadr]});
    endtask

    // Reset values, then the eight INIT writes, then init_done.
    task automatic init_check();
        @(negedge clk);
        chk("rst_ctrl", 32'({gnt0, gnt1, vld0, vld1, rf_we, init_done}), 32'd0);
        chk("rst_rf", 32'({rf_W, rf_W_Adr, rf_R_Adr, rf_S_Adr}), 32'd0);
        chk("rst_dat0", {rdat0, sdat0}, 32'd0);
        chk("rst_dat1", {rdat1, sdat1}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("init_we", 32'({init_done, rf_we}), 32'd1);
            chk("init_adr", 32'(rf_W_Adr), 32'(i));
            chk("init_val", 32'(rf_W), 32'h0000);
        end
        @(negedge clk);
        chk("init_done", 32'({init_done, rf_we}), 32'd2);
        for (int i = 0; i < 8; i++) begin
            shadow[i] = 16'h0000;
            chk("init_mem", 32'(rf_mem[i]), 32'h0000);
        end
    endtask

    // One transaction from requester k; called and returns on a falling edge.
    task automatic do_txn(input int k, input logic we, input logic [2:0] wadr,
                          input logic [15:0] wdat, input logic [2:0] radr,
                          input logic [2:0] sadr, output int waited);
        logic got;
        drive(k, 1'b1, we, wadr, wdat, radr, sadr);
        push_exp(k, radr, sadr);
        if (we) shadow[wadr] = wdat;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 20) begin
            @(negedge clk);
            waited++;
            got = (k == 0) ? gnt0 : gnt1;
        end
        chk("gnt_wait", 32'(got), 32'd1);
        chk("rf_ctl", 32'({rf_we, rf_R_Adr, rf_S_Adr}), 32'({we, radr, sadr}));
        if (we) chk("rf_wr", 32'({rf_W_Adr, rf_W}), 32'({wadr, wdat}));
        drive(k, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        @(negedge clk);
    endtask

    // Both requesters hold read requests for n grants; checks alternation.
    task automatic both_reads(input int n, input int first);
        logic [2:0] a0, b0, a1, b1;
        int         who;
        a0 = 3'($urandom_range(0, 7)); b0 = 3'($urandom_range(0, 7));
        a1 = 3'($urandom_range(0, 7)); b1 = 3'($urandom_range(0, 7));
        drive(0, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), a0, b0);
        drive(1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), a1, b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            who = (first + i) % 2;
            chk("alt_gnt", 32'({gnt1, gnt0}), (who == 1) ? 32'd2 : 32'd1);
            if (gnt0) push_exp(0, a0, b0);
            if (gnt1) push_exp(1, a1, b1);
            if (i == n - 1) begin
                drive(0, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
                drive(1, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int  w;
        logic got;
        int  k;

        // Test 1: reset then INIT pass.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b1;
        init_check();

        // Test 2: write r3 then read it back.
        do_txn(0, 1'b1, 3'd3, 16'hFFFC, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w);
        chk("gnt_latency", 32'(w), 32'd1);
        do_txn(0, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 3'd3, 3'd0, w);

        // Test 4: read-during-write returns old value; next transaction sees new.
        do_txn(0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, w);
        do_txn(1, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 3'd5, 3'd5, w);

        // Test 3: continuous requests alternate (last winner was requester 1).
        both_reads(6, 0);

        // Test 6: tie after a lone requester-0 transaction.
        do_txn(0, 1'b0, 3'd0, 16'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w);
        repeat (2) @(negedge clk);
        both_reads(2, FIXED ? 0 : 1);

        // Test 5: reset while vld1 is pending.
        drive(1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 3'd5, 3'd3);
        push_exp(1, 3'd5, 3'd3);
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            got = gnt1;
        end
        chk("gnt1_before_rst", 32'(got), 32'd1);
        reset = 1'b0;
        exp_q1.delete();
        drive(1, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        init_check();
        do_txn(0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd3, w);

        repeat (3) @(negedge clk);
        chk("q0_drain", 32'(exp_q0.size()), 32'd0);
        chk("q1_drain", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Two-requester access controller for the 8 x 16-bit dual-read, single-write register file (W/W_Adr/we write port, R_Adr/S_Adr read ports, R/S data).
- After reset it sequences an initialisation pass that writes INIT_VAL to every register.
- It then arbitrates one transaction per cycle between two requesters.
- Each transaction is one optional write plus a dual read.
- It sits between the datapath's requesters and the register file and is the only driver of the file's ports.

Parameters:
DW, 16, data width.
AW, 3, register address width; NREG = 2**AW registers.
INIT_VAL, 16'h0000, value written to every register during INIT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset: reset==0 sampled at a rising clk edge resets the block.
req0 / req1  in  1  transaction request; held with its fields until the matching gnt.
we0 / we1  in  1  transaction includes a write.
wadr0 / wadr1  in  AW  write address.
wdat0 / wdat1  in  DW  write data.
radr0 / radr1  in  AW  R-port read address.
sadr0 / sadr1  in  AW  S-port read address.
gnt0 / gnt1  out  1  one-cycle grant pulse.
rdat0 / rdat1  out  DW  captured R-port data.
sdat0 / sdat1  out  DW  captured S-port data.
vld0 / vld1  out  1  one-cycle pulse; rdat/sdat valid.
rf_W  out  DW  register file write data.
rf_W_Adr  out  AW  register file write address.
rf_we  out  1  register file write enable.
rf_R_Adr  out  AW  register file R read address.
rf_S_Adr  out  AW  register file S read address.
rf_R  in  DW  register file R data (combinational read).
rf_S  in  DW  register file S data (combinational read).
init_done  out  1  high once INIT completes.

Behaviour:
- Reset values: all outputs 0, state INIT, init counter 0, last-grant pointer lp=1 (requester 0 wins first tie).
- INIT state:
  - For NREG cycles after reset deasserts: rf_we=1, rf_W=INIT_VAL, rf_W_Adr = counter 0..NREG-1.
  - No gnt is issued; requests stay pending (requester holds req).
  - After the last write: state RUN, init_done=1 (cycle NREG+1 after release).
- RUN state, edge N: sample eligible requests.
  - Requester k is ineligible while gnt_k is high, so one transaction costs a requester at least 2 cycles.
  - Combined throughput is 1 transaction per cycle.
- Arbitration:
  - One eligible: grant it.
  - Both eligible: grant the one != lp.
  - lp updates to the winner.
- Cycle N+1, all outputs registered:
  - gnt_k=1.
  - rf_R_Adr=radr_k, rf_S_Adr=sadr_k.
  - rf_we=we_k, rf_W_Adr=wadr_k, rf_W=wdat_k.
  - When no grant: rf_we=0 and the other rf_* outputs hold their values.
- Edge ending N+1: the write commits; rf_R/rf_S are captured into rdat_k/sdat_k; vld_k=1 during cycle N+2.
  - Read latency is 2 cycles from the sampled request.
  - rdat/sdat hold their values until the next vld_k.
- Read of the address being written in the same transaction returns the OLD value. A transaction granted the following cycle sees the new value.
- Simultaneous write by both requesters to the same address: serialised by arbitration; the later grant wins.
- Reset mid-operation: any pending vld is dropped, outputs return to reset values, INIT restarts and all registers are rewritten.
- Addresses wrap naturally at AW bits. No width extension.

Optional Feature:
RFARB_FIXED_PRIO_EN
- Defined: the both-eligible tie always goes to requester 0; lp is unused.
- Undefined (default): round-robin as above.
- The eligibility rule applies in both modes, so requester 1 is never starved under continuous req0.

Decomposition:
- Package rfarb_pkg holds:
  - state enum {INIT, RUN};
  - DW/AW/INIT_VAL defaults;
  - requester count constant NREQ=2.
- Sub-module rr_arb2: 2-way picker.
  - Inputs: eligible vector and lp.
  - Outputs: one-hot grant.
  - Contains the RFARB_FIXED_PRIO_EN switch.
- The init counter, FSM and port registers live in regfile_arbiter.

Test Plan:
1. reset=0 for 2 cycles, then 1 -> rf_we=1 for 8 cycles with rf_W_Adr 0..7 and rf_W=0000; no gnt; init_done rises the cycle after the address 7 write.
2. After init: req0, we0=1, wadr0=3, wdat0=FFFC -> gnt0 plus rf_we=1, rf_W_Adr=3 next cycle. Then req0, radr0=3, sadr0=0 -> vld0 2 cycles later with rdat0=FFFC, sdat0=0000.
3. req0 and req1 held continuously from init_done -> grant sequence gnt0,gnt1,gnt0,gnt1...; each vld follows its gnt by 1 cycle.
4. req0 writes r5=1234 and reads radr0=5 in the same transaction -> rdat0=0000. Then req1 reads radr1=5, sadr1=5 -> rdat1=sdat1=1234.
5. reset=0 for 1 cycle while vld1 is pending -> vld1 stays 0; INIT reruns; a read of r5 afterwards returns 0000.
6. Tie-break: req0 alone once (lp=0), idle 2 cycles, then req0 and req1 together -> round-robin build grants gnt1 first; RFARB_FIXED_PRIO_EN build grants gnt0 first.
